// File: rtl/apb_arb_pkg.sv
// Shared state encoding, default bus widths and watchdog counter sizing
// for the APB master arbiter.
package apb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  // The watchdog counter only has to reach TIMEOUT-1.
  function automatic int tmo_cnt_w(input int timeout);
    return $clog2(timeout);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or above ptr_i,
// wrapping at NUM_REQ; emits a one-hot grant and its index.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   gnt_idx_o,
  output logic               gnt_vld_o
);

  always_comb begin
    int idx;
    idx       = 0;
    gnt_o     = '0;
    gnt_idx_o = '0;
    gnt_vld_o = 1'b0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = int'(ptr_i) + off;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      if (!gnt_vld_o && req_i[idx]) begin
        gnt_vld_o  = 1'b1;
        gnt_o[idx] = 1'b1;
        gnt_idx_o  = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// Shares one APB master port between NUM_REQ valid/ready requesters (round-robin),
// sequencing SETUP/ACCESS and aborting transfers whose pready stays low too long.
module apb_master_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic                      psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [ADDR_W-1:0]         paddr,
  output logic [DATA_W-1:0]         pwdata,
  input  logic [DATA_W-1:0]         prdata,
  input  logic                      pready
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = tmo_cnt_w(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic                psel_q, penable_q;
  logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;

  logic [NUM_REQ-1:0]  gnt;
  logic [IDX_W-1:0]    gnt_idx;
  logic                gnt_vld;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req_i     (req_valid),
    .ptr_i     (ptr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .gnt_vld_o (gnt_vld)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = 1'b0;
    req_ready   = '0;

    unique case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          req_ready = gnt;
          owner_d   = gnt_idx;
          pwrite_d  = req_write[gnt_idx];
          paddr_d   = req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
          pwdata_d  = req_wdata[int'(gnt_idx)*DATA_W +: DATA_W];
          ptr_d     = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
          cnt_d     = '0;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        if (pready) begin
          rsp_valid_d[owner_q] = 1'b1;
          rsp_rdata_d = pwrite_q ? '0 : prdata;
          state_d     = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          // Watchdog expiry: this is the TIMEOUT-th ACCESS cycle without pready.
          rsp_valid_d[owner_q] = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      cnt_q       <= '0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      psel_q      <= (state_d != IDLE);
      penable_q   <= (state_d == ACCESS);
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Scenario bench for apb_master_arbiter (3 requesters, TIMEOUT=16); responses are
// predicted into a scoreboard queue and matched by a monitor on the falling edge.
module tb_apb_master_arbiter;

  localparam int NR  = 3;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     req_valid, req_ready, req_write, rsp_valid;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_wdata;
  logic [DW-1:0]     rsp_rdata, pwdata, prdata;
  logic              rsp_err, psel, penable, pwrite, pready;
  logic [AW-1:0]     paddr;

  typedef struct {
    int          idx;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] addr_tab [NR];
  logic [31:0] wdata_tab[NR];
  logic        wr_tab   [NR];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;

  apb_master_arbiter #(
    .NUM_REQ (NR),
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .TIMEOUT (TMO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .prdata    (prdata),
    .pready    (pready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Response monitor: every rsp_valid pulse must match the oldest prediction.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && rsp_valid !== '0) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_rsp: got rsp_valid=%b, want no response", rsp_valid);
      end else begin
        mon_e = sb.pop_front();
        if (rsp_valid !== (NR'(1) << mon_e.idx) || rsp_rdata !== mon_e.rdata ||
            rsp_err !== mon_e.err || cyc != mon_e.cyc) begin
          miscompares++;
          $display("FAIL rsp: got valid=%b rdata=%h err=%b cyc=%0d, want valid=%b rdata=%h err=%b cyc=%0d",
                   rsp_valid, rsp_rdata, rsp_err, cyc, NR'(1) << mon_e.idx,
                   mon_e.rdata, mon_e.err, mon_e.cyc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1, "tb watchdog expired");
  end

  task automatic set_req(input int i, input logic w, input logic [31:0] a, input logic [31:0] d);
    wr_tab[i]             = w;
    addr_tab[i]           = a;
    wdata_tab[i]          = d;
    req_write[i]          = w;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = '0;
    pready    = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Presents vmask, expects requester g to win, then walks SETUP/ACCESS driving
  // pready after `waits` wait states (waits < 0: never, i.e. watchdog abort).
  task automatic run_xfer(input logic [NR-1:0] vmask, input bit keep, input int g,
                          input int waits, input logic [31:0] rd);
    exp_t e;
    bit   done;
    int   n;
    req_valid = vmask;
    #1;
    n = 0;
    while (req_ready === '0 && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    vectors++;
    if (req_ready !== (NR'(1) << g)) begin
      miscompares++;
      $display("FAIL grant: got req_ready=%b, want %b", req_ready, NR'(1) << g);
    end
    @(negedge clk);
    if (!keep) req_valid = '0;
    vectors++;
    if (psel !== 1'b1 || penable !== 1'b0 || paddr !== addr_tab[g] ||
        pwrite !== wr_tab[g] || pwdata !== wdata_tab[g] || req_ready !== '0) begin
      miscompares++;
      $display("FAIL setup: got psel=%b penable=%b paddr=%h pwrite=%b pwdata=%h ready=%b, want 1 0 %h %b %h 0",
               psel, penable, paddr, pwrite, pwdata, req_ready, addr_tab[g], wr_tab[g], wdata_tab[g]);
    end
    done = 1'b0;
    for (int k = 0; k < TMO && !done; k++) begin
      @(negedge clk);
      vectors++;
      if (psel !== 1'b1 || penable !== 1'b1 || paddr !== addr_tab[g] || req_ready !== '0) begin
        miscompares++;
        $display("FAIL access%0d: got psel=%b penable=%b paddr=%h ready=%b, want 1 1 %h 0",
                 k, psel, penable, paddr, req_ready, addr_tab[g]);
      end
      prdata = $urandom;
      e.idx  = g;
      e.cyc  = cyc + 1;
      if (k == waits) begin
        pready  = 1'b1;
        prdata  = rd;
        e.rdata = wr_tab[g] ? 32'h0 : rd;
        e.err   = 1'b0;
        sb.push_back(e);
        done = 1'b1;
      end else begin
        pready = 1'b0;
        if (k == TMO - 1) begin
          e.rdata = 32'h0;
          e.err   = 1'b1;
          sb.push_back(e);
          done = 1'b1;
        end
      end
    end
    @(negedge clk);
    pready = 1'b0;
    vectors++;
    if (psel !== 1'b0 || penable !== 1'b0 || paddr !== addr_tab[g] || pwdata !== wdata_tab[g]) begin
      miscompares++;
      $display("FAIL idle_hold: got psel=%b penable=%b paddr=%h pwdata=%h, want 0 0 %h %h",
               psel, penable, paddr, pwdata, addr_tab[g], wdata_tab[g]);
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    pready    = 1'b0;
    prdata    = '0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({psel, penable, pwrite, rsp_err} !== 4'b0 || paddr !== '0 || pwdata !== '0 ||
        rsp_rdata !== '0 || rsp_valid !== '0 || req_ready !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got psel=%b penable=%b pwrite=%b paddr=%h pwdata=%h rsp=%b/%h/%b ready=%b, want all 0",
               psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err, req_ready);
    end
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (psel !== 1'b0 || req_ready !== '0) begin
      miscompares++;
      $display("FAIL idle_no_req: got psel=%b ready=%b, want 0 000", psel, req_ready);
    end
  endtask

  task automatic test_zero_wait_write();
    set_req(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    run_xfer(3'b001, 1'b0, 0, 0, 32'hFFFF_FFFF);
  endtask

  task automatic test_wait_read();
    set_req(1, 1'b0, 32'h0000_0020, 32'h0BAD_F00D);
    run_xfer(3'b010, 1'b0, 1, 3, 32'h1234_5678);
  endtask

  task automatic test_contention();
    int order[4] = '{0, 1, 0, 1};
    apply_reset();
    set_req(0, 1'b1, 32'h0000_0100, 32'hAAAA_0000);
    set_req(1, 1'b0, 32'h0000_0200, 32'hBBBB_0000);
    for (int t = 0; t < 4; t++) begin
      run_xfer(3'b011, 1'b1, order[t], 0, 32'hC0DE_0000 + t);
    end
    req_valid = '0;
  endtask

  task automatic test_timeout();
    set_req(0, 1'b0, 32'h0000_0300, 32'h0);
    run_xfer(3'b001, 1'b0, 0, -1, 32'h0);
    set_req(1, 1'b1, 32'h0000_0304, 32'h5555_AAAA);
    run_xfer(3'b010, 1'b0, 1, 0, 32'h0);
  endtask

  task automatic test_reset_mid();
    int n;
    set_req(1, 1'b0, 32'h0000_0400, 32'h0);
    req_valid = 3'b010;
    #1;
    n = 0;
    while (req_ready === '0 && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    @(negedge clk);
    req_valid = '0;
    repeat (2) @(negedge clk);
    vectors++;
    if (psel !== 1'b1 || penable !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_reset_access: got psel=%b penable=%b, want 1 1", psel, penable);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (psel !== 1'b0 || penable !== 1'b0 || rsp_valid !== '0) begin
      miscompares++;
      $display("FAIL async_reset: got psel=%b penable=%b rsp_valid=%b, want 0 0 000",
               psel, penable, rsp_valid);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    vectors++;
    if (rsp_valid !== '0 || psel !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset_quiet: got rsp_valid=%b psel=%b, want 000 0", rsp_valid, psel);
    end
    set_req(0, 1'b1, 32'h0000_0500, 32'h0101_0101);
    set_req(2, 1'b1, 32'h0000_0508, 32'h0202_0202);
    run_xfer(3'b101, 1'b0, 0, 0, 32'h0);
  endtask

  task automatic test_wrap();
    apply_reset();
    set_req(0, 1'b0, 32'h0000_A000, 32'h1111_1111);
    set_req(1, 1'b1, 32'h0000_B000, 32'h2222_2222);
    set_req(2, 1'b1, 32'h0000_C000, 32'h3333_3333);
    run_xfer(3'b100, 1'b0, 2, 0, 32'h0);
    run_xfer(3'b001, 1'b0, 0, 1, 32'h8765_4321);
    run_xfer(3'b111, 1'b0, 1, 0, 32'h0);
  endtask

  initial begin
    test_reset();
    test_zero_wait_write();
    test_wait_read();
    test_contention();
    test_timeout();
    test_reset_mid();
    test_wrap();
    repeat (3) @(negedge clk);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL missing_rsp: got %0d responses outstanding, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
